// File: rtl/k8088_bus_arbiter.sv
// k8088_bus_arbiter: shares the core's single memory port with one DMA requester.
// The core is frozen through cpu_chipen while DMA owns the bus; bursts are bounded by a CPU gap.
module k8088_bus_arbiter #(
  parameter int DMA_BURST_MAX = 16,
  parameter int CPU_MIN_SLOTS = 1,
  parameter bit PREEMPT_ANY   = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  input  logic        cpu_m0,
  output logic        cpu_chipen,
  output logic [7:0]  cpu_in,
  input  logic        dma_req,
  input  logic [19:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_we,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        dma_rvalid,
  output logic [19:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [1:0]  owner
);

  localparam logic [7:0] BURST_LAST = 8'(DMA_BURST_MAX - 1);
  localparam logic [7:0] GAP_INIT   = 8'(CPU_MIN_SLOTS - 1);

  typedef enum logic [1:0] {
    S_CPU = 2'd0,
    S_DMA = 2'd1,
    S_GAP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  dma_rdata_q, dma_rdata_d;
  logic        dma_rvalid_q, dma_rvalid_d;

  logic        ack_s;
  logic        grant_s;
  logic        last_s;
  logic        rd_ack_s;

  // A core write in flight blocks the grant so it lands before the freeze.
  assign ack_s    = (state_q == S_DMA) & dma_req;
  assign grant_s  = dma_req & ~cpu_we & (PREEMPT_ANY | cpu_m0);
  assign last_s   = ack_s & (burst_cnt_q == BURST_LAST);
  assign rd_ack_s = ack_s & ~dma_we;

  assign cpu_in     = mem_rdata;
  assign dma_ack    = ack_s;
  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;

  // Ownership sequencing and burst/gap counting.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    case (state_q)
      S_CPU: begin
        if (grant_s) begin
          state_d     = S_DMA;
          burst_cnt_d = 8'd0;
        end else begin
          state_d = S_CPU;
        end
      end
      S_DMA: begin
        if (!ack_s) begin
          state_d = S_CPU;
        end else if (last_s) begin
          // Hold the count on the final transfer so a 256 burst never wraps.
          state_d   = S_GAP;
          gap_cnt_d = GAP_INIT;
        end else begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = S_CPU;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_CPU;
      end
    endcase
  end

  // Memory port mux and core freeze, decoded from the registered owner.
  always_comb begin
    mem_address = cpu_address;
    mem_wdata   = cpu_out;
    mem_we      = cpu_we;
    cpu_chipen  = 1'b1;
    owner       = 2'd0;
    case (state_q)
      S_CPU: begin
        owner = 2'd0;
      end
      S_DMA: begin
        mem_address = dma_addr;
        mem_wdata   = dma_wdata;
        mem_we      = dma_we & dma_req;
        cpu_chipen  = 1'b0;
        owner       = 2'd1;
      end
      S_GAP: begin
        owner = 2'd2;
      end
      default: begin
        owner = 2'd0;
      end
    endcase
  end

  // Read-return capture for the DMA side.
  always_comb begin
    dma_rvalid_d = rd_ack_s;
    if (rd_ack_s) begin
      dma_rdata_d = mem_rdata;
    end else begin
      dma_rdata_d = dma_rdata_q;
    end
  end

  // State and data registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_CPU;
      burst_cnt_q  <= 8'd0;
      gap_cnt_q    <= 8'd0;
      dma_rdata_q  <= 8'd0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

endmodule

// File: tb/tb_k8088_bus_arbiter.sv
// Bench for k8088_bus_arbiter: directed scenarios with literal expectations plus a long random run
// checked every cycle against an ownership model and a reference memory image.
module tb_k8088_bus_arbiter;

  localparam int BURST = 4;
  localparam int GAP   = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [19:0] cpu_address;
  logic [7:0]  cpu_out;
  logic        cpu_we;
  logic        cpu_m0;
  logic        cpu_chipen;
  logic [7:0]  cpu_in;
  logic        dma_req;
  logic [19:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_we;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;
  logic [19:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [1:0]  owner;

  int checks = 0;
  int failures = 0;

  k8088_bus_arbiter #(
    .DMA_BURST_MAX(BURST),
    .CPU_MIN_SLOTS(GAP),
    .PREEMPT_ANY(1'b0)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we), .cpu_m0(cpu_m0),
    .cpu_chipen(cpu_chipen), .cpu_in(cpu_in),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  always #20 clock = ~clock;

  // Memories store value XOR a per-address pattern, so an unwritten byte reads as the pattern.
  function automatic logic [7:0] pat(input logic [19:0] a);
    return a[7:0] ^ {a[11:8], a[19:16]} ^ 8'h5A;
  endfunction

  bit [7:0] mem_x [0:1048575];
  bit [7:0] ref_x [0:1048575];

  assign mem_rdata = mem_x[mem_address] ^ pat(mem_address);

  always @(posedge clock) begin
    if (mem_we) mem_x[mem_address] <= mem_wdata ^ pat(mem_address);
  end

  function automatic logic [7:0] mem_rd(input logic [19:0] a);
    return mem_x[a] ^ pat(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [19:0] a);
    return ref_x[a] ^ pat(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Ownership model: DMA holds the bus until it stops asking or has done BURST transfers,
  // after which the core is guaranteed GAP cycles before DMA may be considered again.
  bit          m_dma = 1'b0;
  int          m_xfers = 0;
  int          m_gap_left = 0;
  bit          m_rv = 1'b0;
  logic [7:0]  m_rd = 8'd0;
  bit          last_chipen = 1'b1;
  bit          last_ack = 1'b0;
  logic [1:0]  e_owner;
  logic        e_ack, e_we;
  logic [19:0] e_addr;
  logic [7:0]  e_wd;

  initial forever begin
    @(negedge clock);
    last_chipen = cpu_chipen;
    last_ack    = dma_ack;
    if (!reset_n) begin
      chk("rst_owner", owner, 2'd0);
      chk("rst_chipen", cpu_chipen, 1'b1);
      chk("rst_ack", dma_ack, 1'b0);
      chk("rst_rvalid", dma_rvalid, 1'b0);
      chk("rst_rdata", dma_rdata, 8'd0);
      chk("rst_mem_we", mem_we, cpu_we);
      if (cpu_we) ref_x[cpu_address] = cpu_out ^ pat(cpu_address);
      m_dma = 1'b0; m_gap_left = 0; m_rv = 1'b0; m_rd = 8'd0;
    end else begin
      e_owner = m_dma ? 2'd1 : ((m_gap_left > 0) ? 2'd2 : 2'd0);
      e_ack   = m_dma && dma_req;
      e_addr  = m_dma ? dma_addr : cpu_address;
      e_wd    = m_dma ? dma_wdata : cpu_out;
      e_we    = m_dma ? (dma_we && dma_req) : cpu_we;
      chk("owner", owner, e_owner);
      chk("chipen", cpu_chipen, !m_dma);
      chk("ack", dma_ack, e_ack);
      chk("mem_address", mem_address, e_addr);
      chk("mem_we", mem_we, e_we);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("cpu_in", cpu_in, ref_rd(e_addr));
      chk("rvalid", dma_rvalid, m_rv);
      chk("rdata", dma_rdata, m_rd);
      m_rv = e_ack && !dma_we;
      if (m_rv) m_rd = ref_rd(dma_addr);
      if (e_we) ref_x[e_addr] = e_wd ^ pat(e_addr);
      if (m_dma) begin
        if (dma_req) begin
          m_xfers++;
          if (m_xfers == BURST) begin
            m_dma = 1'b0;
            m_gap_left = GAP;
          end
        end else begin
          m_dma = 1'b0;
        end
      end else if (m_gap_left > 0) begin
        m_gap_left--;
      end else if (dma_req && !cpu_we && cpu_m0) begin
        m_dma = 1'b1;
        m_xfers = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic at_neg();
    @(negedge clock); #1;
  endtask

  int dma_issued = 0;
  int dma_done = 0;

  task automatic new_cpu_op();
    cpu_address = 20'($urandom_range(0, 32'hFFFF));
    cpu_we      = ($urandom_range(0, 3) == 0);
    cpu_out     = 8'($urandom);
    cpu_m0      = ($urandom_range(0, 2) == 0);
  endtask

  task automatic new_dma_op();
    if ($urandom_range(0, 4) == 0) begin
      dma_req = 1'b0;
    end else begin
      dma_req   = 1'b1;
      dma_addr  = 20'($urandom_range(32'h10000, 32'hFFFFF));
      dma_we    = 1'($urandom_range(0, 1));
      dma_wdata = 8'($urandom);
      dma_issued++;
    end
  endtask

  initial begin
    logic [1:0] eo [10];
    logic       ea [10];
    bit         prev_a;
    int         k;
    int         diffs;

    reset_n = 1'b0;
    cpu_address = 20'h00400; cpu_out = 8'd0; cpu_we = 1'b0; cpu_m0 = 1'b0;
    dma_req = 1'b0; dma_addr = 20'h0; dma_wdata = 8'd0; dma_we = 1'b0;
    repeat (2) tick();
    at_neg();
    chk("reset_owner_lit", owner, 2'd0);
    chk("reset_chipen_lit", cpu_chipen, 1'b1);
    chk("reset_rvalid_lit", dma_rvalid, 1'b0);
    tick();
    reset_n = 1'b1;

    // Request held while the core is away from its boundary cycle.
    dma_req = 1'b1; dma_addr = 20'h20000; dma_we = 1'b0;
    repeat (3) begin
      at_neg();
      chk("m0_wait_ack", dma_ack, 1'b0);
      chk("m0_wait_owner", owner, 2'd0);
      tick();
    end
    cpu_m0 = 1'b1;
    at_neg();
    chk("m0_edge_ack", dma_ack, 1'b0);
    tick();
    cpu_m0 = 1'b0;
    at_neg();
    chk("m0_grant_owner", owner, 2'd1);
    chk("m0_grant_ack", dma_ack, 1'b1);
    chk("m0_grant_chipen", cpu_chipen, 1'b0);
    tick();
    dma_req = 1'b0;
    at_neg();
    chk("dead_owner", owner, 2'd1);
    chk("dead_ack", dma_ack, 1'b0);
    chk("m0_rdata", dma_rdata, mem_rd(20'h20000));
    tick();
    at_neg();
    chk("dead_after_owner", owner, 2'd0);

    // Held read stream: four acks, two gap cycles, then a fresh grant.
    eo = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1};
    ea = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tick();
    cpu_m0 = 1'b1; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 20'h00100;
    k = 0; prev_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      chk("burst_owner", owner, eo[i]);
      chk("burst_ack", dma_ack, ea[i]);
      if (eo[i] == 2'd2) chk("gap_chipen", cpu_chipen, 1'b1);
      if (prev_a) begin
        chk("burst_rvalid", dma_rvalid, 1'b1);
        chk("burst_rdata", dma_rdata, mem_rd(20'h00100 + 20'(k - 1)));
      end
      prev_a = ea[i];
      tick();
      if (last_ack) begin
        k++;
        dma_addr = 20'h00100 + 20'(k);
      end
    end
    chk("burst_ack_count", k, 6);
    dma_req = 1'b0;
    at_neg();
    chk("burst_dead_owner", owner, 2'd1);
    chk("burst_last_rdata", dma_rdata, mem_rd(20'h00105));
    tick();

    // Core write in flight when DMA asks: the write lands, the grant comes later.
    cpu_we = 1'b1; cpu_out = 8'h3C; cpu_address = 20'h00200;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 20'h30000;
    at_neg();
    chk("wr_block_mem_addr", mem_address, 20'h00200);
    chk("wr_block_mem_we", mem_we, 1'b1);
    tick();
    cpu_we = 1'b0;
    at_neg();
    chk("wr_block_owner", owner, 2'd0);
    chk("wr_landed", mem_rd(20'h00200), 8'h3C);
    tick();
    at_neg();
    chk("wr_late_grant", dma_ack, 1'b1);
    tick();
    dma_req = 1'b0;
    tick();

    // Single DMA write then release.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 20'h12345; dma_wdata = 8'hA5;
    at_neg();
    chk("dw_owner0", owner, 2'd0);
    tick();
    at_neg();
    chk("dw_ack", dma_ack, 1'b1);
    chk("dw_mem_addr", mem_address, 20'h12345);
    tick();
    dma_req = 1'b0;
    at_neg();
    chk("dw_dead_owner", owner, 2'd1);
    chk("dw_dead_ack", dma_ack, 1'b0);
    chk("dw_mem_value", mem_rd(20'h12345), 8'hA5);
    tick();
    at_neg();
    chk("dw_release_owner", owner, 2'd0);
    tick();

    // Asynchronous reset in the middle of a burst, read pending and write presented.
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 20'h40000;
    at_neg();
    tick();
    at_neg();
    chk("ar_ack_before", dma_ack, 1'b1);
    tick();
    dma_we = 1'b1; dma_addr = 20'h40001; dma_wdata = 8'h77;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_chipen", cpu_chipen, 1'b1);
    chk("ar_ack", dma_ack, 1'b0);
    chk("ar_owner", owner, 2'd0);
    chk("ar_rvalid", dma_rvalid, 1'b0);
    chk("ar_mem_we", mem_we, 1'b0);
    dma_req = 1'b0; dma_we = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    at_neg();
    chk("ar_no_write", mem_rd(20'h40001), pat(20'h40001));

    // Random interleaving of a frozen-aware core and a level-held DMA requester.
    tick();
    new_cpu_op();
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (last_ack) dma_done++;
      if (last_chipen) new_cpu_op();
      if (last_ack || !dma_req) new_dma_op();
    end
    for (int c = 0; c < 200 && dma_req; c++) begin
      tick();
      if (last_chipen) new_cpu_op();
      if (last_ack) begin
        dma_done++;
        dma_req = 1'b0;
      end
    end
    chk("dma_drained", dma_req, 1'b0);
    chk("dma_all_done", dma_done, dma_issued);
    cpu_we = 1'b0;
    dma_req = 1'b0;
    tick();
    tick();
    diffs = 0;
    for (int a = 0; a < 1048576; a++) begin
      if (mem_x[a] != ref_x[a]) diffs++;
    end
    chk("mem_image", diffs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/k8088_bus_arbiter.md
# k8088_bus_arbiter

Shares the single 8-bit, 20-bit-address memory port between the k8088 core and one DMA requester. It sequences CPU ownership through the core's `chipen` freeze input: while the DMA channel owns the bus, the CPU is held frozen and memory is driven from the DMA side. Burst length is bounded and the CPU gets guaranteed slots between bursts. The block sits between the core, the DMA engine and the memory/IO decoder.

## Interface
- `DMA_BURST_MAX`, 16: maximum consecutive DMA transfers per grant, legal range 1..256.
- `CPU_MIN_SLOTS`, 1: minimum CPU-owned cycles after an exhausted burst, legal range 1..256.
- `PREEMPT_ANY`, 0: 1 = DMA may take the bus on any eligible cycle; 0 = only when `cpu_m0`=1.

Ports:
- `clock` in 1: system clock, 25 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_address` in 20: core address.
- `cpu_out` in 8: core write data.
- `cpu_we` in 1: core write strobe.
- `cpu_m0` in 1: core is at its instruction-boundary (LOAD) cycle.
- `cpu_chipen` out 1: core enable; 0 freezes the core.
- `cpu_in` out 8: read data to the core.
- `dma_req` in 1: DMA transfer request, level-held per transfer.
- `dma_addr` in 20: DMA address.
- `dma_wdata` in 8: DMA write data.
- `dma_we` in 1: DMA transfer is a write.
- `dma_ack` out 1: the transfer presented this cycle is performed.
- `dma_rdata` out 8: registered read data.
- `dma_rvalid` out 1: `dma_rdata` valid (1-cycle pulse).
- `mem_address` out 20, `mem_wdata` out 8, `mem_we` out 1: shared memory port.
- `mem_rdata` in 8: memory read data, combinational (valid in the same cycle as the address).
- `owner` out 2: 0 = CPU, 1 = DMA, 2 = GAP.

## Operation
- States: S_CPU, S_DMA and S_GAP, held in a register. Counters: `burst_cnt` (8 bit) and `gap_cnt` (8 bit).
- The mux is combinational from the registered state:
  - S_CPU/S_GAP: the mem port carries `cpu_*`; `cpu_chipen`=1.
  - S_DMA: the mem port carries `dma_*`; `mem_we` = `dma_we` & `dma_req`; `cpu_chipen`=0.
- `cpu_in` = `mem_rdata` always. The core ignores it while frozen.
- `dma_ack` = (state==S_DMA) & `dma_req`.
- S_CPU -> S_DMA requires all of the following: `dma_req`=1, `cpu_we`=0, and (`PREEMPT_ANY` or `cpu_m0`). `burst_cnt` is set to 0.
  - Do not preempt while `cpu_we`=1: this guarantees a core write completes before the core freezes.
- S_DMA, in each acked cycle, `burst_cnt`++ occurs. Then:
  - If the ack was the `DMA_BURST_MAX`-th transfer, go to S_GAP and set `gap_cnt`=`CPU_MIN_SLOTS`-1.
  - If `dma_req`=0, go to S_CPU. No ack occurs; this is one dead cycle with the core still frozen.
- S_GAP: decrement `gap_cnt`; when it is 0, go to S_CPU. A `dma_req` is ignored in S_GAP.
- On an acked read (`dma_we`=0), `dma_rdata`<=`mem_rdata` and `dma_rvalid`<=1 on the next edge; otherwise `dma_rvalid`<=0.
- The core's `address` is stable while frozen, so resuming needs no replay.

## Timing
- Reset (asynchronous, immediate) sets:
  - state=S_CPU, `owner`=0, `cpu_chipen`=1;
  - `dma_ack`=0, `dma_rvalid`=0, `dma_rdata`=0, both counters 0.
- Reset mid-burst drops `dma_ack` and `cpu_chipen`→1 with no clock edge; a pending `dma_rvalid` is cancelled.
- Grant latency from `dma_req` rise with eligibility met at edge N: `owner`=1 and `dma_ack`=1 in cycle N+1.
- Back-to-back DMA: one transfer per cycle while `dma_req` is held. Read data appears on `dma_rvalid` one cycle after the ack.
- A full burst occupies `DMA_BURST_MAX` cycles followed by exactly `CPU_MIN_SLOTS` S_GAP cycles. Re-grant requires the S_CPU eligibility check again, so the earliest next ack is at burst end + `CPU_MIN_SLOTS` + 1 cycles.
- Simultaneous `dma_req` rise and `cpu_we`=1: no grant; re-evaluated each cycle.
- Counter wrap: `burst_cnt` never exceeds `DMA_BURST_MAX`. With 256 it compares at 255+ack and never wraps.

## Test plan
- Reset asserted mid-S_DMA, async between edges -> `cpu_chipen`=1, `dma_ack`=0 and `owner`=0 immediately; no further `mem_we` from DMA.
- `PREEMPT_ANY`=0, `dma_req` held from a cycle with `cpu_m0`=0 -> no ack until the cycle after the first `cpu_m0`=1; the core's `ip` is unchanged while frozen.
- `DMA_BURST_MAX`=4, `CPU_MIN_SLOTS`=2, `dma_req` held 10 cycles of reads from 0x00100..:
  - acks 4, then 2 GAP cycles with `cpu_chipen`=1, then grant again;
  - `dma_rdata` matches the memory image byte-by-byte, one cycle after each ack.
- `PREEMPT_ANY`=1, core executing a memory write (`cpu_we`=1) when `dma_req` rises -> the write lands at the core address first; the grant comes on a later cycle.
- DMA writes 0xA5 to 0x12345, then drops `dma_req` -> the memory holds 0xA5; there is one dead cycle (`owner`=1, no ack), then `owner`=0.
- Long random run with interleaved requests -> the core's architectural trace equals a run without DMA, and all DMA transfers are completed exactly once.
